// File: rtl/mux_n_sel_reg.sv
// Registered CH-input, W-bit multiplexer with manual select and round-robin auto-scan.
// Define MUX_PARITY_EN to add the registered even-parity output out_par.
module mux_n_sel_reg #(
    parameter  int CH    = 4,
    parameter  int W     = 8,
    parameter  int DWELL = 1,
    localparam int SELW  = (CH > 1) ? $clog2(CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CH*W-1:0]   in_data,
    input  logic [SELW-1:0]   sel,
    input  logic              mode,
    input  logic              en,
    output logic [W-1:0]      out_data,
    output logic [SELW-1:0]   out_sel,
`ifdef MUX_PARITY_EN
    output logic              out_par,
`endif
    output logic              out_valid
);

    localparam int              DWW     = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DWW-1:0]  DW_LAST = DWW'(DWELL - 1);
    localparam logic [SELW-1:0] CH_LAST = SELW'(CH - 1);
    localparam logic [SELW:0]   CH_NUM  = (SELW + 1)'(CH);

    typedef enum logic [1:0] {
        IDLE,
        MAN,
        SCAN
    } state_t;

    state_t          state_q, state_d;
    logic [SELW-1:0] chCnt_q, chCnt_d;
    logic [DWW-1:0]  dwCnt_q, dwCnt_d;
    logic [W-1:0]    outData_q, outData_d;
    logic [SELW-1:0] outSel_q, outSel_d;
    logic            outValid_q, outValid_d;
    logic            scanLast_q, scanLast_d;
`ifdef MUX_PARITY_EN
    logic            outPar_q, outPar_d;
`endif

    logic            resumeScan;
    logic [SELW-1:0] effCh;
    logic [DWW-1:0]  effDw;

    function automatic logic [W-1:0] pickChannel(input logic [CH*W-1:0] data,
                                                 input logic [SELW-1:0] idx);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < CH; k++) begin
            if (idx == SELW'(k)) begin
                r = data[k*W +: W];
            end
        end
        return r;
    endfunction

    // Scan resumes its frozen position only if the last active mode was scan;
    // any entry into scan coming from manual restarts at channel 0.
    assign resumeScan = (state_q == SCAN) || ((state_q == IDLE) && scanLast_q);

    always_comb begin
        state_d    = state_q;
        chCnt_d    = chCnt_q;
        dwCnt_d    = dwCnt_q;
        outData_d  = outData_q;
        outSel_d   = outSel_q;
        outValid_d = 1'b0;
        scanLast_d = scanLast_q;
        effCh      = chCnt_q;
        effDw      = dwCnt_q;

        if (!en) begin
            state_d = IDLE;
        end else if (!mode) begin
            state_d    = MAN;
            scanLast_d = 1'b0;
            outSel_d   = sel;
            if ({1'b0, sel} < CH_NUM) begin
                outData_d  = pickChannel(in_data, sel);
                outValid_d = 1'b1;
            end else begin
                outData_d  = '0;
                outValid_d = 1'b0;
            end
        end else begin
            state_d    = SCAN;
            scanLast_d = 1'b1;
            if (!resumeScan) begin
                effCh = '0;
                effDw = '0;
            end
            outData_d  = pickChannel(in_data, effCh);
            outSel_d   = effCh;
            outValid_d = 1'b1;
            if (effDw == DW_LAST) begin
                dwCnt_d = '0;
                chCnt_d = (effCh == CH_LAST) ? '0 : effCh + SELW'(1);
            end else begin
                dwCnt_d = effDw + DWW'(1);
                chCnt_d = effCh;
            end
        end
    end

`ifdef MUX_PARITY_EN
    always_comb begin
        outPar_d = outPar_q;
        if (en) begin
            outPar_d = ^outData_d;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            chCnt_q    <= '0;
            dwCnt_q    <= '0;
            outData_q  <= '0;
            outSel_q   <= '0;
            outValid_q <= 1'b0;
            scanLast_q <= 1'b0;
`ifdef MUX_PARITY_EN
            outPar_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            chCnt_q    <= chCnt_d;
            dwCnt_q    <= dwCnt_d;
            outData_q  <= outData_d;
            outSel_q   <= outSel_d;
            outValid_q <= outValid_d;
            scanLast_q <= scanLast_d;
`ifdef MUX_PARITY_EN
            outPar_q   <= outPar_d;
`endif
        end
    end

    assign out_data  = outData_q;
    assign out_sel   = outSel_q;
    assign out_valid = outValid_q;
`ifdef MUX_PARITY_EN
    assign out_par   = outPar_q;
`endif

endmodule

// File: tb/tb_mux_n_sel_reg.sv
// Self-checking bench for mux_n_sel_reg: a CH=4/DWELL=2 instance and a CH=3/DWELL=1
// instance, checked against a step-count reference model under directed and random stimulus.
module tb_mux_n_sel_reg;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [31:0] inA;
    logic [1:0]  selA;
    logic        modeA, enA;
    logic [7:0]  outDataA;
    logic [1:0]  outSelA;
    logic        outValidA;

    logic [23:0] inC;
    logic [1:0]  selC;
    logic        modeC, enC;
    logic [7:0]  outDataC;
    logic [1:0]  outSelC;
    logic        outValidC;

`ifdef MUX_PARITY_EN
    logic        outParA, outParC;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model state, index 0 = instance A, 1 = instance C.
    int          chOf[2] = '{4, 3};
    int          dwOf[2] = '{2, 1};
    bit          mScan[2];
    int          mStep[2];
    logic [7:0]  mData[2];
    int          mSel[2];
    bit          mValid[2];
    bit          mPar[2];

    int          expSel2[10] = '{0, 0, 1, 1, 2, 2, 3, 3, 0, 0};
    logic [7:0]  expDat2[10] = '{8'hAA, 8'hAA, 8'hBB, 8'hBB, 8'hCC, 8'hCC, 8'hDD, 8'hDD, 8'hAA, 8'hAA};
    int          scanSelC[4] = '{0, 1, 2, 0};
    logic [7:0]  scanDatC[4] = '{8'h11, 8'h07, 8'h33, 8'h11};

    always #5 clk = ~clk;

    mux_n_sel_reg #(.CH(4), .W(8), .DWELL(2)) dutA (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (inA),
        .sel      (selA),
        .mode     (modeA),
        .en       (enA),
        .out_data (outDataA),
        .out_sel  (outSelA),
`ifdef MUX_PARITY_EN
        .out_par  (outParA),
`endif
        .out_valid(outValidA)
    );

    mux_n_sel_reg #(.CH(3), .W(8), .DWELL(1)) dutC (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_data  (inC),
        .sel      (selC),
        .mode     (modeC),
        .en       (enC),
        .out_data (outDataC),
        .out_sel  (outSelC),
`ifdef MUX_PARITY_EN
        .out_par  (outParC),
`endif
        .out_valid(outValidC)
    );

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        for (int u = 0; u < 2; u++) begin
            mScan[u]  = 1'b0;
            mStep[u]  = 0;
            mData[u]  = 8'h00;
            mSel[u]   = 0;
            mValid[u] = 1'b0;
            mPar[u]   = 1'b0;
        end
    endtask

    // Scan position is a running count of scan captures; channel = (count / DWELL) mod CH.
    task automatic modelEdge(input int u, input logic e, input logic m, input int s,
                             input logic [31:0] d);
        int ch;
        if (!e) begin
            mValid[u] = 1'b0;
        end else if (!m) begin
            mScan[u] = 1'b0;
            mSel[u]  = s;
            if (s < chOf[u]) begin
                mData[u]  = d[s*8 +: 8];
                mValid[u] = 1'b1;
            end else begin
                mData[u]  = 8'h00;
                mValid[u] = 1'b0;
            end
            mPar[u] = ^mData[u];
        end else begin
            if (!mScan[u]) mStep[u] = 0;
            mScan[u]  = 1'b1;
            ch        = (mStep[u] / dwOf[u]) % chOf[u];
            mData[u]  = d[ch*8 +: 8];
            mSel[u]   = ch;
            mValid[u] = 1'b1;
            mPar[u]   = ^mData[u];
            mStep[u]++;
        end
    endtask

    task automatic checkAgainstModel();
        checkOutput("A.data",  32'(outDataA),  32'(mData[0]));
        checkOutput("A.sel",   32'(outSelA),   32'(mSel[0]));
        checkOutput("A.valid", 32'(outValidA), 32'(mValid[0]));
        checkOutput("C.data",  32'(outDataC),  32'(mData[1]));
        checkOutput("C.sel",   32'(outSelC),   32'(mSel[1]));
        checkOutput("C.valid", 32'(outValidC), 32'(mValid[1]));
`ifdef MUX_PARITY_EN
        checkOutput("A.par",   32'(outParA),   32'(mPar[0]));
        checkOutput("C.par",   32'(outParC),   32'(mPar[1]));
`endif
    endtask

    // One clock: model consumes the inputs the DUTs will sample, then outputs are compared.
    task automatic tick();
        modelEdge(0, enA, modeA, int'(selA), inA);
        modelEdge(1, enC, modeC, int'(selC), {8'h00, inC});
        @(posedge clk);
        #1;
        checkAgainstModel();
    endtask

    task automatic asyncResetPulse(input string tag);
        rst_n = 1'b0;
        #1;
        modelReset();
        checkOutput({tag, ".rstData"},  32'(outDataA),  32'h0);
        checkOutput({tag, ".rstSel"},   32'(outSelA),   32'h0);
        checkOutput({tag, ".rstValid"}, 32'(outValidA), 32'h0);
        checkOutput({tag, ".rstDataC"}, 32'(outDataC),  32'h0);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic applyStimulus();
        enA   = ($urandom_range(0, 7) != 0);
        modeA = ($urandom_range(0, 3) != 0);
        selA  = 2'($urandom_range(0, 3));
        inA   = $urandom;
        enC   = ($urandom_range(0, 7) != 0);
        modeC = ($urandom_range(0, 2) != 0);
        selC  = 2'($urandom_range(0, 3));
        inC   = 24'($urandom);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        inA   = 32'hDDCCBBAA;
        selA  = 2'd2;
        modeA = 1'b0;
        enA   = 1'b1;
        inC   = 24'h330711;
        selC  = 2'd0;
        modeC = 1'b0;
        enC   = 1'b0;
        modelReset();

        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset.data",  32'(outDataA),  32'h0);
        checkOutput("reset.sel",   32'(outSelA),   32'h0);
        checkOutput("reset.valid", 32'(outValidA), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Manual select right after release
        tick();
        checkOutput("man.data",  32'(outDataA),  32'hCC);
        checkOutput("man.sel",   32'(outSelA),   32'd2);
        checkOutput("man.valid", 32'(outValidA), 32'd1);

        // Scan with DWELL=2 from manual
        modeA = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            checkOutput("scan.sel",  32'(outSelA),  32'(expSel2[i]));
            checkOutput("scan.data", 32'(outDataA), 32'(expDat2[i]));
        end

        // Pause after channel 1 shows for its first cycle
        tick();
        checkOutput("pause.first", 32'(outSelA), 32'd1);
        enA = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("pause.valid", 32'(outValidA), 32'd0);
            checkOutput("pause.hold",  32'(outDataA),  32'hBB);
        end
        enA = 1'b1;
        tick();
        checkOutput("resume.again", 32'(outSelA), 32'd1);
        tick();
        checkOutput("resume.next", 32'(outSelA), 32'd2);

        // Mode switch while on channel 3
        for (int i = 0; i < 8 && outSelA != 2'd3; i++) tick();
        checkOutput("switch.reach3", 32'(outSelA), 32'd3);
        modeA = 1'b0;
        selA  = 2'd1;
        tick();
        checkOutput("switch.manData", 32'(outDataA), 32'hBB);
        checkOutput("switch.manSel",  32'(outSelA),  32'd1);
        modeA = 1'b1;
        tick();
        checkOutput("switch.scanData", 32'(outDataA), 32'hAA);
        checkOutput("switch.scanSel",  32'(outSelA),  32'd0);

        // Asynchronous reset between edges while on channel 2
        for (int i = 0; i < 8 && outSelA != 2'd2; i++) tick();
        checkOutput("areset.reach2", 32'(outSelA), 32'd2);
        #1;
        asyncResetPulse("areset");
        tick();
        checkOutput("areset.restartSel",  32'(outSelA),  32'd0);
        checkOutput("areset.restartData", 32'(outDataA), 32'hAA);

        // CH=3 instance: out-of-range select, parity, DWELL=1 scan
        enA  = 1'b0;
        enC  = 1'b1;
        selC = 2'd3;
        tick();
        checkOutput("ch3.badData",  32'(outDataC),  32'h0);
        checkOutput("ch3.badValid", 32'(outValidC), 32'd0);
        checkOutput("ch3.badSel",   32'(outSelC),   32'd3);
        selC = 2'd1;
        tick();
        checkOutput("ch3.data07", 32'(outDataC), 32'h07);
`ifdef MUX_PARITY_EN
        checkOutput("ch3.par07", 32'(outParC), 32'd1);
`endif
        modeC = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput("dwell1.sel",  32'(outSelC),  32'(scanSelC[i]));
            checkOutput("dwell1.data", 32'(outDataC), 32'(scanDatC[i]));
        end

        // Randomized traffic with occasional asynchronous resets
        for (int i = 0; i < 300; i++) begin
            applyStimulus();
            tick();
            if ($urandom_range(0, 39) == 0) begin
                #1;
                asyncResetPulse("rand");
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
